// File: rtl/enum_seq_checker_pkg.sv
// Shared types and constants for the enum sequence checker.
//   enum_t / alias_t          : 8-bit code; ONE, TWO and THREE are the legal values
//   struct_t / second_alias_t : forwarded beat, field x carries the code
//   state_t                   : order-checking FSM states
//   MAX_LEGAL                 : highest legal code; anything above it is illegal
package pkg;
  typedef enum logic [7:0] {
    ONE   = 8'd0,
    TWO   = 8'd1,
    THREE = 8'd2
  } enum_t;

  typedef enum_t alias_t;

  typedef struct packed {
    enum_t x;
  } struct_t;

  typedef struct_t second_alias_t;

  typedef enum logic [1:0] {
    EXP_ONE,
    EXP_TWO,
    EXP_THREE,
    ERR
  } state_t;

  localparam enum_t MAX_LEGAL = THREE;

  function automatic logic is_legal(input alias_t code);
    return code <= MAX_LEGAL;
  endfunction
endpackage

// File: rtl/enum_seq_checker_if.sv
// Stream bundle for the enum sequence checker.
//   in_valid / in_ready / in_data    : upstream beat handshake
//   out_valid / out_ready / out_data : downstream beat handshake
// The slave modport is the checker's view; master is the surrounding logic.
interface enum_seq_checker_if
  import pkg::*;
  ;
  logic          in_valid;
  logic          in_ready;
  alias_t        in_data;
  logic          out_valid;
  logic          out_ready;
  second_alias_t out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/enum_seq_checker_sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   rst_n : synchronous active-low reset, clears the count
//   inc   : add one this cycle unless already at the all-ones value
//   cnt   : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/enum_seq_checker.sv
// Checks that legal codes arrive in ONE, TWO, THREE order and forwards them.
//   clk         : clock
//   rst_n       : synchronous active-low reset
//   bus         : slave stream port (input beats in, forwarded beats out)
//   clr_err     : clears seq_err unless a violation occurs in the same cycle
//   seq_err     : sticky order-violation flag
//   illegal_cnt : saturating count of dropped illegal codes
//   frame_cnt   : saturating count of completed ONE, TWO, THREE sequences
module enum_seq_checker
  import pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  enum_seq_checker_if.slave bus,
  input  logic             clr_err,
  output logic             seq_err,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [CNT_W-1:0] frame_cnt
);
  state_t state, state_nxt;
  logic   acc, legal, fwd, drop;
  logic   viol, frame_inc;

  // A single output register: a new beat may enter whenever the slot is
  // empty or being emptied this cycle.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign acc          = rst_n && bus.in_valid && bus.in_ready;
  assign legal        = is_legal(bus.in_data);
  assign fwd          = acc && legal;
  assign drop         = acc && !legal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EXP_ONE;
    end else begin
      state <= state_nxt;
    end
  end

  // Illegal codes never reach the FSM, so they are transparent to ordering.
  always_comb begin
    state_nxt = state;
    viol      = 1'b0;
    frame_inc = 1'b0;
    if (fwd) begin
      case (state)
        EXP_ONE: begin
          if (bus.in_data == ONE) state_nxt = EXP_TWO;
          else begin state_nxt = ERR; viol = 1'b1; end
        end
        EXP_TWO: begin
          if (bus.in_data == TWO) state_nxt = EXP_THREE;
          else begin state_nxt = ERR; viol = 1'b1; end
        end
        EXP_THREE: begin
          if (bus.in_data == THREE) begin
            state_nxt = EXP_ONE;
            frame_inc = 1'b1;
          end else begin
            state_nxt = ERR;
            viol      = 1'b1;
          end
        end
        ERR: begin
          // Resynchronise on the next ONE; stray TWO/THREE are not new errors.
          if (bus.in_data == ONE) state_nxt = EXP_TWO;
        end
        default: state_nxt = EXP_ONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_err <= 1'b0;
    end else if (viol) begin
      seq_err <= 1'b1;
    end else if (clr_err) begin
      seq_err <= 1'b0;
    end
  end

  // Output register only loads when the slot is free, which keeps the held
  // beat stable under back-pressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (bus.in_ready) begin
      bus.out_valid <= fwd;
      if (fwd) bus.out_data <= '{x: bus.in_data};
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_illegal_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop),
    .cnt   (illegal_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frame_inc),
    .cnt   (frame_cnt)
  );
endmodule

// File: doc/enum_seq_checker.md
ENUM_SEQ_CHECKER -- requirements
Module: enum_seq_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the illegal-code and frame counters.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream beat valid.
REQ-005 SHALL have port in_ready  output  1  this block accepts a beat.
REQ-006 SHALL have port in_data  input  8  code, typed pkg::alias_t.
REQ-007 SHALL have port out_valid  output  1  forwarded beat valid.
REQ-008 SHALL have port out_ready  input  1  downstream accepts.
REQ-009 SHALL have port out_data  output  8  forwarded code, typed pkg::second_alias_t (field x = code).
REQ-010 SHALL have port clr_err  input  1  clears seq_err.
REQ-011 SHALL have port seq_err  output  1  sticky order-violation flag.
REQ-012 SHALL have port illegal_cnt  output  CNT_W  count of dropped illegal codes.
REQ-013 SHALL have port frame_cnt  output  CNT_W  count of completed ONE,TWO,THREE sequences.

Function
REQ-014 SHALL accept a beat when in_valid && in_ready; in_ready = !out_valid || out_ready (single output register, no bubble under back-pressure).
REQ-015 SHALL present an accepted legal beat on out_data/out_valid the cycle after acceptance (latency 1).
REQ-016 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-017 SHALL treat codes 0..2 (ONE, TWO, THREE) as legal; codes 3..255 as illegal.
REQ-018 SHALL drop accepted illegal beats (not forwarded), increment illegal_cnt saturating at 2^CNT_W-1, leave FSM state unchanged.
REQ-019 SHALL implement FSM states EXP_ONE, EXP_TWO, EXP_THREE, ERR, advancing only on accepted legal beats.
REQ-020 SHALL transition EXP_ONE->EXP_TWO on ONE, EXP_TWO->EXP_THREE on TWO, EXP_THREE->EXP_ONE on THREE, incrementing frame_cnt (saturating) on the THREE.
REQ-021 SHALL go to ERR and set seq_err on any legal code other than the expected one.
REQ-022 SHALL in ERR ignore TWO/THREE and resynchronise to EXP_TWO on ONE; seq_err remains set.
REQ-023 SHALL forward all legal beats regardless of order correctness.
REQ-024 SHALL clear seq_err on clr_err, except a new violation in the same cycle wins (seq_err stays 1).
REQ-025 SHALL not count a sequence whose ONE or TWO was followed by an illegal code as broken (illegal beats are transparent to order).

Reset
REQ-026 SHALL on rst_n low at a clock edge set: FSM EXP_ONE, out_valid 0, out_data 0, seq_err 0, illegal_cnt 0, frame_cnt 0; in_ready is 1 in the first cycle after reset.
REQ-027 SHALL discard any held output beat on reset mid-transfer; no beat is accepted in a cycle with rst_n low.

Structure
REQ-028 SHALL place the FSM state enum and a code-legality constant (max legal = THREE) in package pkg, alongside enum_t/alias_t/struct_t/second_alias_t.
REQ-029 SHALL implement saturating counters as one sub-module sat_counter (parameter width, inc input), instantiated twice.

Verification
REQ-030 SHALL cover: ONE,TWO,THREE,ONE,TWO,THREE back-to-back, out_ready=1 -> six beats out 1 cycle later, frame_cnt=2, seq_err=0.
REQ-031 SHALL cover: ONE,THREE,TWO,ONE,TWO,THREE -> seq_err=1 after THREE, frame_cnt=1, all six beats forwarded.
REQ-032 SHALL cover: ONE,0x07,TWO,0xFF,THREE -> illegal_cnt=2, only 3 beats forwarded, frame_cnt=1, seq_err=0.
REQ-033 SHALL cover: out_ready=0 for 5 cycles with continuous in_valid -> in_ready=0 after first beat held, out_data stable, no loss on release.
REQ-034 SHALL cover: CNT_W=2, five illegal codes -> illegal_cnt saturates at 3; clr_err coincident with violation -> seq_err=1.
REQ-035 SHALL cover: rst_n low while out_valid=1 and FSM in EXP_THREE -> all outputs reset next cycle, next ONE accepted cleanly.
